// File: rtl/fcp_pkg.sv
// Shared definitions for the FCP output-voltage controller: level encoding,
// DAC setpoints and the controller state type.
package fcp_pkg;

  // Voltage level encoding shared by req_volt and cur_volt
  localparam logic [1:0] LVL_5V   = 2'b00;
  localparam logic [1:0] LVL_9V   = 2'b01;
  localparam logic [1:0] LVL_12V  = 2'b10;
  localparam logic [1:0] LVL_RSVD = 2'b11;

  // Power-stage setpoints in 100 mV units
  localparam logic [7:0] DAC_5V  = 8'd50;
  localparam logic [7:0] DAC_9V  = 8'd90;
  localparam logic [7:0] DAC_12V = 8'd120;

  // Legal setpoint window; the ramp never leaves it
  localparam logic [7:0] DAC_MIN = DAC_5V;
  localparam logic [7:0] DAC_MAX = DAC_12V;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RAMP   = 2'b01,
    ST_SETTLE = 2'b10,
    ST_FAULT  = 2'b11
  } fcp_state_e;

  // Setpoint for a level; the reserved code maps to the safe 5V setpoint
  function automatic logic [7:0] level_to_dac(input logic [1:0] lvl);
    case (lvl)
      LVL_9V:  return DAC_9V;
      LVL_12V: return DAC_12V;
      default: return DAC_5V;
    endcase
  endfunction

  // A request is honoured only for 5V, 9V, or 12V when the board supports it
  function automatic logic level_valid(input logic [1:0] lvl, input logic support_12v);
    case (lvl)
      LVL_5V:  return 1'b1;
      LVL_9V:  return 1'b1;
      LVL_12V: return support_12v;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fcp_pg_debounce.sv
// Power-good debouncer: counts consecutive equal pg samples. The stable flags
// include the sample being taken on the coming edge, so the controller can act
// on the same edge that completes the run. clr restarts both runs, letting the
// current sample count as the first of a new run.
module fcp_pg_debounce
  import fcp_pkg::*;
#(
  parameter int PG_DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic pg,
  output logic pg_hi_stable,
  output logic pg_lo_stable
);

  localparam int CW = $clog2(PG_DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PG_DEBOUNCE);

  logic [CW-1:0] hi_cnt;
  logic [CW-1:0] lo_cnt;
  logic [CW-1:0] hi_nxt;
  logic [CW-1:0] lo_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CW'(1);
  endfunction

  // Extend the run matching the current sample, zero the opposite run
  always_comb begin
    hi_nxt = '0;
    lo_nxt = '0;
    if (pg) begin
      hi_nxt = sat_inc(clr ? '0 : hi_cnt);
    end else begin
      lo_nxt = sat_inc(clr ? '0 : lo_cnt);
    end
  end

  assign pg_hi_stable = (hi_nxt == CNT_MAX);
  assign pg_lo_stable = (lo_nxt == CNT_MAX);

  // Run-length registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      hi_cnt <= hi_nxt;
      lo_cnt <= lo_nxt;
    end
  end

endmodule

// File: rtl/fcp_volt_ctrl.sv
// FCP output-voltage controller: accepts level requests, ramps the power-stage
// DAC one code at a time, waits for debounced power-good, and latches a sticky
// fault on settle timeout or loss of power-good at a raised level.
module fcp_volt_ctrl
  import fcp_pkg::*;
#(
  parameter int STEP_CYCLES    = 100,
  parameter int SETTLE_TIMEOUT = 10000,
  parameter int PG_DEBOUNCE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_volt,
  input  logic       is_support_12v,
  input  logic       master_reset,
  input  logic       pg,
  output logic [7:0] dac_code,
  output logic [1:0] cur_volt,
  output logic       volt_busy,
  output logic       fault
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int TO_W   = $clog2(SETTLE_TIMEOUT + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(SETTLE_TIMEOUT);

  fcp_state_e        state, state_n;
  logic [1:0]        target, target_n;
  logic [7:0]        dac_n;
  logic [1:0]        cur_n;
  logic              busy_n;
  logic              fault_n;
  logic [STEP_W-1:0] step_cnt, step_n;
  logic [TO_W-1:0]   to_cnt, to_n;
  logic [7:0]        tgt_code;
  logic              fault_entry;
  logic              req_ok;
  logic              db_clr;
  logic              pg_hi_stable;
  logic              pg_lo_stable;

  // Clamp a signed candidate setpoint into the legal DAC window
  function automatic logic [7:0] dac_sat(input logic signed [9:0] v);
    if (v < signed'({2'b00, DAC_MIN})) return DAC_MIN;
    if (v > signed'({2'b00, DAC_MAX})) return DAC_MAX;
    return v[7:0];
  endfunction

  // One code toward the target; direction is decided fresh at every step
  function automatic logic [7:0] dac_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [9:0] nxt;
    nxt = signed'({2'b00, cur}) + ((tgt > cur) ? 10'sd1 : -10'sd1);
    return dac_sat(nxt);
  endfunction

  assign req_ok = level_valid(req_volt, is_support_12v);

  // Runs are restarted while ramping or faulted so that SETTLE and IDLE
  // decisions only see power-good history from after the ramp ended.
  assign db_clr = (state == ST_RAMP) || (state == ST_FAULT);

  fcp_pg_debounce #(
    .PG_DEBOUNCE (PG_DEBOUNCE)
  ) u_pg_debounce (
    .clk          (clk),
    .rst          (rst),
    .clr          (db_clr),
    .pg           (pg),
    .pg_hi_stable (pg_hi_stable),
    .pg_lo_stable (pg_lo_stable)
  );

  // Next-state, counter and output decode
  always_comb begin
    state_n     = state;
    target_n    = target;
    dac_n       = dac_code;
    cur_n       = cur_volt;
    busy_n      = volt_busy;
    fault_n     = fault;
    step_n      = step_cnt;
    to_n        = to_cnt;
    tgt_code    = level_to_dac(target);
    fault_entry = 1'b0;

    case (state)
      ST_IDLE: begin
        step_n = '0;
        to_n   = '0;
        if (master_reset) begin
          target_n = LVL_5V;
          state_n  = ST_RAMP;
          busy_n   = 1'b1;
        end else if ((cur_volt != LVL_5V) && pg_lo_stable) begin
          fault_entry = 1'b1;
        end else if (req_ok && (req_volt != cur_volt)) begin
          target_n = req_volt;
          state_n  = ST_RAMP;
          busy_n   = 1'b1;
        end
      end

      ST_RAMP: begin
        // Retarget without disturbing the step cadence or the current code
        if (master_reset) begin
          target_n = LVL_5V;
        end else if (req_ok) begin
          target_n = req_volt;
        end
        tgt_code = level_to_dac(target_n);
        if (dac_code == tgt_code) begin
          state_n = ST_SETTLE;
          step_n  = '0;
          to_n    = '0;
        end else if (step_cnt == STEP_LAST) begin
          dac_n  = dac_step(dac_code, tgt_code);
          step_n = '0;
        end else begin
          step_n = step_cnt + STEP_W'(1);
        end
      end

      ST_SETTLE: begin
        if (master_reset) begin
          target_n = LVL_5V;
          state_n  = ST_RAMP;
          step_n   = '0;
        end else if (pg_hi_stable) begin
          cur_n   = target;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
          to_n    = '0;
        end else if ((to_cnt + TO_W'(1)) == TO_LIMIT) begin
          fault_entry = 1'b1;
        end else begin
          to_n = to_cnt + TO_W'(1);
        end
      end

      ST_FAULT: begin
        if (master_reset) begin
          fault_n = 1'b0;
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Fault entry drops the supply to the safe setpoint on the same edge
    if (fault_entry) begin
      state_n  = ST_FAULT;
      target_n = LVL_5V;
      dac_n    = DAC_5V;
      cur_n    = LVL_5V;
      fault_n  = 1'b1;
      busy_n   = 1'b0;
      step_n   = '0;
      to_n     = '0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      target    <= LVL_5V;
      dac_code  <= DAC_5V;
      cur_volt  <= LVL_5V;
      volt_busy <= 1'b0;
      fault     <= 1'b0;
      step_cnt  <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      dac_code  <= dac_n;
      cur_volt  <= cur_n;
      volt_busy <= busy_n;
      fault     <= fault_n;
      step_cnt  <= step_n;
      to_cnt    <= to_n;
    end
  end

endmodule

// File: tb/tb_fcp_volt_ctrl.sv
// Directed bench for fcp_volt_ctrl with STEP_CYCLES=4, SETTLE_TIMEOUT=64,
// PG_DEBOUNCE=4. Expected values are hand-computed cycle counts.
module tb_fcp_volt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_volt;
  logic       is_support_12v;
  logic       master_reset;
  logic       pg;
  logic [7:0] dac_code;
  logic [1:0] cur_volt;
  logic       volt_busy;
  logic       fault;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] req;
    logic       s12;
    logic       mr;
    logic       pg;
    int         ncyc;
    logic [7:0] dac;
    logic [1:0] cur;
    logic       busy;
    logic       flt;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  fcp_volt_ctrl #(
    .STEP_CYCLES    (4),
    .SETTLE_TIMEOUT (64),
    .PG_DEBOUNCE    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_volt       (req_volt),
    .is_support_12v (is_support_12v),
    .master_reset   (master_reset),
    .pg             (pg),
    .dac_code       (dac_code),
    .cur_volt       (cur_volt),
    .volt_busy      (volt_busy),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] req, input logic s12, input logic mr,
                              input logic p, input int ncyc, input logic [7:0] dac,
                              input logic [1:0] cur, input logic busy, input logic flt,
                              input string nm);
    vec_t v;
    v.req = req; v.s12 = s12; v.mr = mr; v.pg = p; v.ncyc = ncyc;
    v.dac = dac; v.cur = cur; v.busy = busy; v.flt = flt; v.nm = nm;
    return v;
  endfunction

  // Advance n rising edges, then step 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] e_dac, input logic [1:0] e_cur,
                     input logic e_busy, input logic e_flt);
    n_chk++;
    if (dac_code !== e_dac) begin
      n_fail++;
      $display("FAIL %s dac_code: got %0d expected %0d", nm, dac_code, e_dac);
    end
    n_chk++;
    if (cur_volt !== e_cur) begin
      n_fail++;
      $display("FAIL %s cur_volt: got %b expected %b", nm, cur_volt, e_cur);
    end
    n_chk++;
    if (volt_busy !== e_busy) begin
      n_fail++;
      $display("FAIL %s volt_busy: got %b expected %b", nm, volt_busy, e_busy);
    end
    n_chk++;
    if (fault !== e_flt) begin
      n_fail++;
      $display("FAIL %s fault: got %b expected %b", nm, fault, e_flt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_volt = 2'b00; is_support_12v = 1'b0; master_reset = 1'b0; pg = 1'b1;
    #1 rst = 1'b1;
    #2 chk("reset_async", 8'd50, 2'b00, 1'b0, 1'b0);
    tick(2);
    chk("reset_hold", 8'd50, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;

    //              req  s12  mr   pg  ncyc  dac  cur  busy flt
    vecs.push_back(mk(2'd0, 1'b0, 1'b0, 1'b1,   3,  50, 2'd0, 1'b0, 1'b0, "idle_hold"));
    vecs.push_back(mk(2'd2, 1'b0, 1'b0, 1'b1,   3,  50, 2'd0, 1'b0, 1'b0, "req12_unsupported"));
    vecs.push_back(mk(2'd3, 1'b1, 1'b0, 1'b1,   3,  50, 2'd0, 1'b0, 1'b0, "req_reserved"));
    vecs.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1,   2,  50, 2'd0, 1'b0, 1'b0, "req_equals_cur"));
    vecs.push_back(mk(2'd1, 1'b1, 1'b0, 1'b1,   1,  50, 2'd0, 1'b1, 1'b0, "ramp9_entry"));
    vecs.push_back(mk(2'd1, 1'b1, 1'b0, 1'b1,   4,  51, 2'd0, 1'b1, 1'b0, "ramp9_first_step"));
    vecs.push_back(mk(2'd1, 1'b1, 1'b0, 1'b1, 156,  90, 2'd0, 1'b1, 1'b0, "ramp9_at_target"));
    vecs.push_back(mk(2'd1, 1'b1, 1'b0, 1'b1,   3,  90, 2'd0, 1'b1, 1'b0, "settle9_debounce"));
    vecs.push_back(mk(2'd1, 1'b1, 1'b0, 1'b1,   1,  90, 2'd1, 1'b0, 1'b0, "settled9"));
    vecs.push_back(mk(2'd2, 1'b1, 1'b0, 1'b1,   1,  90, 2'd1, 1'b1, 1'b0, "ramp12_entry"));
    vecs.push_back(mk(2'd2, 1'b1, 1'b0, 1'b1, 120, 120, 2'd1, 1'b1, 1'b0, "ramp12_at_target"));
    vecs.push_back(mk(2'd2, 1'b1, 1'b0, 1'b1,   4, 120, 2'd2, 1'b0, 1'b0, "settled12"));
    vecs.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0,   3, 120, 2'd2, 1'b0, 1'b0, "pg_glitch3"));
    vecs.push_back(mk(2'd2, 1'b1, 1'b0, 1'b1,   2, 120, 2'd2, 1'b0, 1'b0, "pg_recover"));
    vecs.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0,   3, 120, 2'd2, 1'b0, 1'b0, "pg_drop3"));
    vecs.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0,   1,  50, 2'd0, 1'b0, 1'b1, "pg_drop4_fault"));
    vecs.push_back(mk(2'd1, 1'b1, 1'b0, 1'b1,   3,  50, 2'd0, 1'b0, 1'b1, "fault_ignores_req"));
    vecs.push_back(mk(2'd0, 1'b1, 1'b1, 1'b1,   1,  50, 2'd0, 1'b0, 1'b0, "fault_cleared"));
    vecs.push_back(mk(2'd0, 1'b1, 1'b1, 1'b1,   1,  50, 2'd0, 1'b1, 1'b0, "mrst_at_5v"));
    vecs.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1,   1,  50, 2'd0, 1'b1, 1'b0, "zero_step_settle"));
    vecs.push_back(mk(2'd1, 1'b1, 1'b0, 1'b1,   2,  50, 2'd0, 1'b1, 1'b0, "settle_ignores_req"));
    vecs.push_back(mk(2'd1, 1'b1, 1'b0, 1'b1,   1,  50, 2'd0, 1'b0, 1'b0, "settled5"));
    vecs.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1,   2,  50, 2'd0, 1'b0, 1'b0, "idle_after_settle"));

    for (int i = 0; i < vecs.size(); i++) begin
      req_volt       = vecs[i].req;
      is_support_12v = vecs[i].s12;
      master_reset   = vecs[i].mr;
      pg             = vecs[i].pg;
      tick(vecs[i].ncyc);
      chk(vecs[i].nm, vecs[i].dac, vecs[i].cur, vecs[i].busy, vecs[i].flt);
    end

    // master_reset at dac_code=70 while ramping to 9V reverses the ramp
    req_volt = 2'd1;
    tick(1);
    chk("rev_entry", 8'd50, 2'd0, 1'b1, 1'b0);
    tick(80);
    chk("rev_at70", 8'd70, 2'd0, 1'b1, 1'b0);
    master_reset = 1'b1; req_volt = 2'd0;
    tick(1);
    master_reset = 1'b0;
    chk("rev_mrst", 8'd70, 2'd0, 1'b1, 1'b0);
    tick(3);
    chk("rev_first_down", 8'd69, 2'd0, 1'b1, 1'b0);
    tick(76);
    chk("rev_at50", 8'd50, 2'd0, 1'b1, 1'b0);
    tick(4);
    chk("rev_settled", 8'd50, 2'd0, 1'b0, 1'b0);

    // pg held low through SETTLE: timeout fault, then cleared by master_reset
    pg = 1'b0; req_volt = 2'd1;
    tick(1);
    chk("to_entry", 8'd50, 2'd0, 1'b1, 1'b0);
    tick(160);
    chk("to_at90", 8'd90, 2'd0, 1'b1, 1'b0);
    tick(64);
    chk("to_before_edge", 8'd90, 2'd0, 1'b1, 1'b0);
    tick(1);
    chk("to_fault", 8'd50, 2'd0, 1'b0, 1'b1);
    tick(3);
    chk("to_fault_sticky", 8'd50, 2'd0, 1'b0, 1'b1);
    master_reset = 1'b1; req_volt = 2'd0;
    tick(1);
    master_reset = 1'b0;
    chk("to_cleared", 8'd50, 2'd0, 1'b0, 1'b0);
    tick(2);
    chk("to_idle", 8'd50, 2'd0, 1'b0, 1'b0);
    req_volt = 2'd1;
    tick(1);
    chk("to_idle_accepts", 8'd50, 2'd0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of that ramp
    tick(120);
    chk("arst_at80", 8'd80, 2'd0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk("arst_immediate", 8'd50, 2'd0, 1'b0, 1'b0);
    tick(3);
    chk("arst_no_steps", 8'd50, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; req_volt = 2'd0;
    tick(8);
    chk("arst_idle", 8'd50, 2'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
